// File: rtl/rr_arbiter_16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: sizes, FSM encoding
// and the index-to-one-hot helper used for the select lines.
package rr_arbiter_16_pkg;

   localparam int N_REQ = 16;
   localparam int IDX_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot16(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = {N_REQ{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Requester-side bundle of the arbiter: request/enable/release in,
// grant index, one-hot select and timeout pulse out.
interface rr_arbiter_16_if;
   import rr_arbiter_16_pkg::*;

   logic             en;
   logic [N_REQ-1:0] req;
   logic             done;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic [N_REQ-1:0] gnt_oh;
   logic             timeout;

   modport master (
      output en, req, done,
      input  gnt_valid, gnt_idx, gnt_oh, timeout
   );

   modport slave (
      input  en, req, done,
      output gnt_valid, gnt_idx, gnt_oh, timeout
   );

endinterface

// File: rtl/rr_arbiter_16_pick16.sv
// Rotating-priority pick: the first set request found scanning upward from
// ptr with wrap-around; rotate, encode LSB-first, then rotate the index back.
module rr_pick16
   import rr_arbiter_16_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [N_REQ-1:0] rot_s;
   logic [IDX_W-1:0] enc_s;

   // rotate so ptr lands at bit 0, then find the lowest set bit
   always_comb begin
      rot_s = N_REQ'({req, req} >> ptr);
      enc_s = {IDX_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            enc_s = IDX_W'(i);
         end else begin
            enc_s = enc_s;
         end
      end
   end

   assign any = |req;
   assign idx = enc_s + ptr;

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for one shared slot among 16 requesters: grant is held
// until done, request drop or hold timeout, then priority moves past the holder.
module rr_arbiter_16
   import rr_arbiter_16_pkg::*;
#(
   parameter int HOLD_W   = 8,
   parameter int HOLD_MAX = 255
) (
   input  logic            clk,
   input  logic            rst,
   rr_arbiter_16_if.slave  arb
);

   localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
   localparam logic              TMO_EN    = (HOLD_MAX != 0);

   state_t           state_r, state_nx_s;
   logic [IDX_W-1:0] ptr_r, ptr_nx_s;
   logic [IDX_W-1:0] gnt_idx_r, gnt_idx_nx_s;
   logic [HOLD_W-1:0] hold_r, hold_nx_s;
   logic             gnt_valid_r, gnt_valid_nx_s;
   logic             timeout_r, timeout_nx_s;

   logic             pick_any_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             rel_done_s, rel_drop_s, rel_tmo_s, release_s;

   rr_pick16 u_pick (
      .req (arb.req),
      .ptr (ptr_r),
      .any (pick_any_s),
      .idx (pick_idx_s)
   );

   assign rel_done_s = arb.done;
   assign rel_drop_s = ~arb.req[gnt_idx_r];
   assign rel_tmo_s  = TMO_EN && (hold_r == HOLD_LAST);
   assign release_s  = rel_done_s | rel_drop_s | rel_tmo_s;

   // next-state and next-register values for the grant FSM
   always_comb begin
      state_nx_s     = state_r;
      ptr_nx_s       = ptr_r;
      gnt_idx_nx_s   = gnt_idx_r;
      hold_nx_s      = hold_r;
      gnt_valid_nx_s = gnt_valid_r;
      timeout_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arb.en && pick_any_s) begin
               state_nx_s     = ST_BUSY;
               gnt_idx_nx_s   = pick_idx_s;
               gnt_valid_nx_s = 1'b1;
               hold_nx_s      = {HOLD_W{1'b0}};
            end else begin
               gnt_valid_nx_s = 1'b0;
            end
         end
         ST_BUSY: begin
            if (hold_r != HOLD_SAT) begin
               hold_nx_s = hold_r + HOLD_ONE;
            end else begin
               hold_nx_s = hold_r;
            end
            if (release_s) begin
               state_nx_s     = ST_IDLE;
               gnt_valid_nx_s = 1'b0;
               ptr_nx_s       = gnt_idx_r + 4'd1;
               // a forced release only counts as a timeout when nothing else ended the grant
               timeout_nx_s   = rel_tmo_s & ~rel_done_s & ~rel_drop_s;
            end else begin
               gnt_valid_nx_s = 1'b1;
            end
         end
         default: begin
            state_nx_s     = ST_IDLE;
            gnt_valid_nx_s = 1'b0;
         end
      endcase
   end

   // state and grant registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= {IDX_W{1'b0}};
         gnt_idx_r   <= {IDX_W{1'b0}};
         hold_r      <= {HOLD_W{1'b0}};
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         ptr_r       <= ptr_nx_s;
         gnt_idx_r   <= gnt_idx_nx_s;
         hold_r      <= hold_nx_s;
         gnt_valid_r <= gnt_valid_nx_s;
         timeout_r   <= timeout_nx_s;
      end
   end

   assign arb.gnt_valid = gnt_valid_r;
   assign arb.gnt_idx   = gnt_idx_r;
   assign arb.timeout   = timeout_r;
   assign arb.gnt_oh    = onehot16(gnt_idx_r) & {N_REQ{gnt_valid_r}};

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: each step queues the hand-derived outputs
// expected after the next clock edge; a monitor pops and compares them.
module tb_rr_arbiter_16;
   import rr_arbiter_16_pkg::*;

   logic clk = 1'b0;
   logic rst;

   rr_arbiter_16_if bus ();

   rr_arbiter_16 #(
      .HOLD_W   (8),
      .HOLD_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .arb (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [3:0]  i;
      logic        t;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_x;
   logic [15:0] mon_oh;
   int          n_vec  = 0;
   int          n_miss = 0;

   task automatic step(input logic r, input logic e, input logic [15:0] q, input logic d,
                       input logic ev, input logic [3:0] ei, input logic et, input string tag);
      exp_t x;
      @(negedge clk);
      rst      = r;
      bus.en   = e;
      bus.req  = q;
      bus.done = d;
      x.v   = ev;
      x.i   = ei;
      x.t   = et;
      x.tag = tag;
      sb_q.push_back(x);
   endtask

   // scoreboard monitor: compare DUT outputs just after each edge
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_x  = sb_q.pop_front();
         mon_oh = mon_x.v ? (16'h0001 << mon_x.i) : 16'h0000;
         n_vec++;
         if (bus.gnt_valid !== mon_x.v || bus.gnt_idx !== mon_x.i ||
             bus.gnt_oh !== mon_oh || bus.timeout !== mon_x.t) begin
            n_miss++;
            $display("FAIL %s: got valid=%0b idx=%0d oh=%h timeout=%0b, expected valid=%0b idx=%0d oh=%h timeout=%0b",
                     mon_x.tag, bus.gnt_valid, bus.gnt_idx, bus.gnt_oh, bus.timeout,
                     mon_x.v, mon_x.i, mon_oh, mon_x.t);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      bus.en   = 1'b0;
      bus.req  = 16'h0000;
      bus.done = 1'b0;

      // reset with all requests pending, then first grant goes to 0
      step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, "reset0");
      step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, "reset1");
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 4'd0, 1'b0, "first_grant");
      step(1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 4'd0, 1'b0, "first_release");

      // rotation between 15 and 0
      step(1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 4'd15, 1'b0, "rot_g15a");
      step(1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0, "rot_idle1");
      step(1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 4'd0,  1'b0, "rot_g0");
      step(1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 4'd0,  1'b0, "rot_idle2");
      step(1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 4'd15, 1'b0, "rot_g15b");
      step(1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0, "rot_idle3");

      // wrap: after granting 14 the pointer is 15, so 0 beats 14
      step(1'b0, 1'b1, 16'h4000, 1'b0, 1'b1, 4'd14, 1'b0, "wrap_g14");
      step(1'b0, 1'b1, 16'h4001, 1'b1, 1'b0, 4'd14, 1'b0, "wrap_rel14");
      step(1'b0, 1'b1, 16'h4001, 1'b0, 1'b1, 4'd0,  1'b0, "wrap_g0");
      step(1'b0, 1'b1, 16'h4001, 1'b1, 1'b0, 4'd0,  1'b0, "wrap_rel0");

      // timeout after four held cycles, then re-grant
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "tmo_hold0");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "tmo_hold1");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "tmo_hold2");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "tmo_hold3");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 4'd4, 1'b1, "tmo_pulse");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "tmo_regrant");

      // done coincides with the last hold cycle: plain release
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "sim_hold1");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "sim_hold2");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "sim_hold3");
      step(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 4'd4, 1'b0, "sim_done_tmo");

      // requester drop ends the grant
      step(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 4'd5, 1'b0, "drop_g5");
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 4'd5, 1'b0, "drop_rel");
      step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd5, 1'b0, "no_req");

      // enable low during a grant: grant survives, no new grant afterwards
      step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 4'd8, 1'b0, "en_g8");
      step(1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 4'd8, 1'b0, "en_off_hold");
      step(1'b0, 1'b0, 16'h0300, 1'b0, 1'b1, 4'd8, 1'b0, "en_other_req");
      step(1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 4'd8, 1'b0, "en_off_rel");
      step(1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4'd8, 1'b0, "en_off_idle");
      step(1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 4'd8, 1'b0, "idle_done");

      // reset in the middle of a grant clears everything and the pointer
      step(1'b0, 1'b1, 16'h0400, 1'b0, 1'b1, 4'd10, 1'b0, "rst_g10");
      step(1'b1, 1'b1, 16'h0400, 1'b0, 1'b0, 4'd0,  1'b0, "rst_mid");
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 4'd0,  1'b0, "rst_ptr0");
      step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'd0,  1'b0, "rst_rel");
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 4'd1,  1'b0, "rst_next1");

      repeat (2) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
